mp3_frame_sync: RTL and testbench

Upstream framing stage of the MP3 parser. It consumes the raw byte stream from the file or SD source, hunts for an MPEG-1 Layer III frame sync, and validates and decodes the 4-byte frame header. It forwards the frame body bytes, with CRC bytes removed, together with a frame-relative byte counter. The side-information parser and later stages consume this stream directly.

---
 rtl/mp3_frame_sync.sv | 182 ++++++++++++++++++
 tb/tb_mp3_frame_sync.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_frame_sync.sv
`default_nettype none
// ============================================================================
// Module   : mp3_frame_sync
// Brief    : MPEG-1 Layer III frame sync hunter, header decoder and body
//            forwarder with CRC-byte removal and frame-relative byte counter.
// Revision : 1.0 - initial release
// ============================================================================
module mp3_frame_sync (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  axiid,
   input  logic        axiiv,
   output logic [7:0]  axiod,
   output logic        axiov,
   output logic [31:0] counter,
   output logic        header_valid,
   output logic [3:0]  bitrate_idx,
   output logic [1:0]  samp_idx,
   output logic        padding,
   output logic [1:0]  channel_mode,
   output logic [1:0]  mode_ext,
   output logic        crc_present,
   output logic        mono,
   output logic [10:0] frame_len,
   output logic        frame_done
);

   localparam logic [7:0]  c_sync     = 8'hFF;
   localparam logic [10:0] c_hdr_len  = 11'd4;
   localparam logic [10:0] c_crc_last = 11'd5;

   typedef enum logic [2:0] {
      S_HUNT = 3'd0,
      S_H1   = 3'd1,
      S_H2   = 3'd2,
      S_H3   = 3'd3,
      S_CRC  = 3'd4,
      S_BODY = 3'd5
   } state_t;

   state_t      r_state;
   logic [10:0] r_idx;
   logic        r_crc;
   logic [3:0]  r_br;
   logic [1:0]  r_sr;
   logic        r_pad;

   logic        w_h1_ok;
   logic        w_h2_ok;
   logic [10:0] w_lut_len;
   logic [10:0] w_body_cnt;

   // floor(144 * bitrate / fs) for MPEG-1 Layer III; 0 for reserved indices
   function automatic logic [10:0] f_frame_len(input logic [3:0] br, input logic [1:0] sr);
      logic [10:0] v;
      v = 11'd0;
      case (sr)
         2'd0: case (br)
            4'd1: v = 11'd104;   4'd2: v = 11'd130;   4'd3: v = 11'd156;
            4'd4: v = 11'd182;   4'd5: v = 11'd208;   4'd6: v = 11'd261;
            4'd7: v = 11'd313;   4'd8: v = 11'd365;   4'd9: v = 11'd417;
            4'd10: v = 11'd522;  4'd11: v = 11'd626;  4'd12: v = 11'd731;
            4'd13: v = 11'd835;  4'd14: v = 11'd1044;
            default: v = 11'd0;
         endcase
         2'd1: case (br)
            4'd1: v = 11'd96;    4'd2: v = 11'd120;   4'd3: v = 11'd144;
            4'd4: v = 11'd168;   4'd5: v = 11'd192;   4'd6: v = 11'd240;
            4'd7: v = 11'd288;   4'd8: v = 11'd336;   4'd9: v = 11'd384;
            4'd10: v = 11'd480;  4'd11: v = 11'd576;  4'd12: v = 11'd672;
            4'd13: v = 11'd768;  4'd14: v = 11'd960;
            default: v = 11'd0;
         endcase
         2'd2: case (br)
            4'd1: v = 11'd144;   4'd2: v = 11'd180;   4'd3: v = 11'd216;
            4'd4: v = 11'd252;   4'd5: v = 11'd288;   4'd6: v = 11'd360;
            4'd7: v = 11'd432;   4'd8: v = 11'd504;   4'd9: v = 11'd576;
            4'd10: v = 11'd720;  4'd11: v = 11'd864;  4'd12: v = 11'd1008;
            4'd13: v = 11'd1152; 4'd14: v = 11'd1440;
            default: v = 11'd0;
         endcase
         default: v = 11'd0;
      endcase
      return v;
   endfunction

   assign w_h1_ok    = (axiid[7:5] == 3'b111) && (axiid[4:3] == 2'b11) && (axiid[2:1] == 2'b01);
   assign w_h2_ok    = (axiid[7:4] != 4'd0) && (axiid[7:4] != 4'd15) && (axiid[3:2] != 2'd3);
   assign w_lut_len  = f_frame_len(r_br, r_sr);
   // The internal index includes the CRC bytes; the published counter does not
   assign w_body_cnt = r_idx - (crc_present ? 11'd2 : 11'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_HUNT;
         r_idx        <= 11'd0;
         r_crc        <= 1'b0;
         r_br         <= 4'd0;
         r_sr         <= 2'd0;
         r_pad        <= 1'b0;
         axiod        <= 8'd0;
         axiov        <= 1'b0;
         counter      <= 32'd0;
         header_valid <= 1'b0;
         bitrate_idx  <= 4'd0;
         samp_idx     <= 2'd0;
         padding      <= 1'b0;
         channel_mode <= 2'd0;
         mode_ext     <= 2'd0;
         crc_present  <= 1'b0;
         mono         <= 1'b0;
         frame_len    <= 11'd0;
         frame_done   <= 1'b0;
      end else begin
         axiov        <= 1'b0;
         header_valid <= 1'b0;
         frame_done   <= 1'b0;
         if (r_state == S_HUNT) begin
            counter <= 32'd0;
         end
         if (axiiv) begin
            case (r_state)
               S_HUNT: begin
                  if (axiid == c_sync) begin
                     r_state <= S_H1;
                  end
               end
               S_H1: begin
                  if (w_h1_ok) begin
                     r_crc   <= ~axiid[0];
                     r_state <= S_H2;
                  end else begin
                     r_state <= (axiid == c_sync) ? S_H1 : S_HUNT;
                  end
               end
               S_H2: begin
                  if (w_h2_ok) begin
                     r_br    <= axiid[7:4];
                     r_sr    <= axiid[3:2];
                     r_pad   <= axiid[1];
                     r_state <= S_H3;
                  end else begin
                     r_state <= (axiid == c_sync) ? S_H1 : S_HUNT;
                  end
               end
               S_H3: begin
                  header_valid <= 1'b1;
                  bitrate_idx  <= r_br;
                  samp_idx     <= r_sr;
                  padding      <= r_pad;
                  crc_present  <= r_crc;
                  channel_mode <= axiid[7:6];
                  mode_ext     <= axiid[5:4];
                  mono         <= (axiid[7:6] == 2'b11);
                  frame_len    <= w_lut_len + {10'd0, r_pad};
                  r_idx        <= c_hdr_len;
                  r_state      <= r_crc ? S_CRC : S_BODY;
               end
               S_CRC: begin
                  r_idx <= r_idx + 11'd1;
                  if (r_idx == c_crc_last) begin
                     r_state <= S_BODY;
                  end
               end
               S_BODY: begin
                  axiod   <= axiid;
                  axiov   <= 1'b1;
                  counter <= {21'd0, w_body_cnt};
                  r_idx   <= r_idx + 11'd1;
                  if (r_idx == frame_len - 11'd1) begin
                     frame_done <= 1'b1;
                     r_state    <= S_HUNT;
                  end
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mp3_frame_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mp3_frame_sync
// Brief    : Randomised and directed bench for mp3_frame_sync with a
//            frame-level reference model built from the header rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp3_frame_sync;

   logic        clk;
   logic        rst_n;
   logic [7:0]  axiid;
   logic        axiiv;
   logic [7:0]  axiod;
   logic        axiov;
   logic [31:0] counter;
   logic        header_valid;
   logic [3:0]  bitrate_idx;
   logic [1:0]  samp_idx;
   logic        padding;
   logic [1:0]  channel_mode;
   logic [1:0]  mode_ext;
   logic        crc_present;
   logic        mono;
   logic [10:0] frame_len;
   logic        frame_done;

   mp3_frame_sync dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .axiid        (axiid),
      .axiiv        (axiiv),
      .axiod        (axiod),
      .axiov        (axiov),
      .counter      (counter),
      .header_valid (header_valid),
      .bitrate_idx  (bitrate_idx),
      .samp_idx     (samp_idx),
      .padding      (padding),
      .channel_mode (channel_mode),
      .mode_ext     (mode_ext),
      .crc_present  (crc_present),
      .mono         (mono),
      .frame_len    (frame_len),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      int         cnt;
      bit         done;
   } exp_byte_t;

   typedef struct {
      int br;
      int sr;
      int pad;
      int cm;
      int me;
      int crc;
      int len;
   } exp_hdr_t;

   exp_byte_t exp_q[$];
   exp_hdr_t  exp_h[$];
   int vectors     = 0;
   int miscompares = 0;
   int hdr_seen    = 0;
   int body_starts = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Frame size straight from the definition: floor(144 * bitrate / fs) + padding
   function automatic int model_len(int br, int sr, int pad);
      int kbps[15] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320};
      int fs[3]    = '{44100, 48000, 32000};
      return (144 * kbps[br] * 1000) / fs[sr] + pad;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         axiiv = 1'b0;
         axiid = 8'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   // gap: 0 none, 1 one idle cycle before every byte, 2 random 0..2 idle cycles
   task automatic put(input logic [7:0] b, input int gap);
      if (gap == 1) idle(1);
      else if (gap == 2) idle(int'($urandom_range(0, 2)));
      axiid = b;
      axiiv = 1'b1;
      @(posedge clk);
      #1;
      axiiv = 1'b0;
   endtask

   // body_limit < 0 sends the whole frame, otherwise only that many body bytes
   task automatic send_frame(input int crc, input int br, input int sr, input int pad,
                             input int cm, input int me, input int gap, input int body_limit,
                             input logic [15:0] crc_word);
      exp_hdr_t  h;
      exp_byte_t e;
      int        nbody;
      int        nsend;
      logic [7:0] b[$];
      h.br = br; h.sr = sr; h.pad = pad; h.cm = cm; h.me = me; h.crc = crc;
      h.len = model_len(br, sr, pad);
      exp_h.push_back(h);
      nbody = h.len - 4 - (crc != 0 ? 2 : 0);
      nsend = (body_limit < 0) ? nbody : body_limit;
      for (int i = 0; i < nsend; i++) begin
         e.d    = 8'($urandom);
         e.cnt  = 4 + i;
         e.done = (i == nbody - 1);
         b.push_back(e.d);
         exp_q.push_back(e);
      end
      put(8'hFF, gap);
      put((crc != 0) ? 8'hFA : 8'hFB, gap);
      put({4'(br), 2'(sr), 1'(pad), 1'b0}, gap);
      put({2'(cm), 2'(me), 4'b0100}, gap);
      if (crc != 0) begin
         put(crc_word[15:8], gap);
         put(crc_word[7:0], gap);
      end
      for (int i = 0; i < nsend; i++) put(b[i], gap);
   endtask

   always @(negedge clk) begin
      exp_hdr_t  h;
      exp_byte_t e;
      if (rst_n) begin
         if (header_valid) begin
            if (exp_h.size() == 0) begin
               chk("unexpected_header_valid", 32'(header_valid), 32'd0);
            end else begin
               h = exp_h.pop_front();
               hdr_seen++;
               chk("bitrate_idx",  32'(bitrate_idx),  32'(h.br));
               chk("samp_idx",     32'(samp_idx),     32'(h.sr));
               chk("padding",      32'(padding),      32'(h.pad));
               chk("channel_mode", 32'(channel_mode), 32'(h.cm));
               chk("mode_ext",     32'(mode_ext),     32'(h.me));
               chk("crc_present",  32'(crc_present),  32'(h.crc));
               chk("mono",         32'(mono),         32'(h.cm == 3));
               chk("frame_len",    32'(frame_len),    32'(h.len));
            end
         end
         if (axiov) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_axiov", 32'(axiov), 32'd0);
            end else begin
               e = exp_q.pop_front();
               if (e.cnt == 4) begin
                  chk("header_before_body", 32'(hdr_seen > body_starts), 32'd1);
                  body_starts++;
               end
               chk("axiod",      32'(axiod),      32'(e.d));
               chk("counter",    counter,         32'(e.cnt));
               chk("frame_done", 32'(frame_done), 32'(e.done));
            end
         end else if (frame_done) begin
            chk("frame_done_without_axiov", 32'(frame_done), 32'd0);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_axiod"},        32'(axiod),        32'd0);
      chk({tag, "_axiov"},        32'(axiov),        32'd0);
      chk({tag, "_counter"},      counter,           32'd0);
      chk({tag, "_header_valid"}, 32'(header_valid), 32'd0);
      chk({tag, "_frame_done"},   32'(frame_done),   32'd0);
      chk({tag, "_hdr_fields"},
          32'({bitrate_idx, samp_idx, padding, channel_mode, mode_ext, crc_present, mono}), 32'd0);
      chk({tag, "_frame_len"},    32'(frame_len),    32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int crc_r;
      int br_r;
      int sr_r;
      rst_n = 1'b0;
      axiiv = 1'b0;
      axiid = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(2);

      // No CRC, stereo: FF FB 90 64, 413 body bytes
      send_frame(0, 9, 0, 0, 1, 2, 0, -1, 16'h0);
      idle(3);
      chk("frame_len_417", 32'(frame_len), 32'd417);

      // CRC present, mono: FF FA 90 C4 AA BB ...
      send_frame(1, 9, 0, 0, 3, 0, 0, -1, 16'hAABB);
      idle(3);
      chk("mono_after_crc_frame", 32'(mono), 32'd1);

      // Rejected headers: bad bitrate, reserved sample rate
      put(8'hFF, 0); put(8'hFB, 0); put(8'hF0, 0); put(8'h00, 0);
      put(8'hFF, 0); put(8'hFB, 0); put(8'h9C, 0); put(8'h00, 0);
      idle(3);
      // FF failing in H2 is itself a sync candidate
      put(8'hFF, 0); put(8'hFB, 0);
      send_frame(0, 5, 1, 0, 0, 0, 0, -1, 16'h0);
      // FF FF FB 90 64: sync at the second FF
      put(8'hFF, 0);
      send_frame(0, 9, 0, 0, 1, 2, 0, -1, 16'h0);
      idle(3);

      // 320k @ 32k padded, then a second frame with no gap after frame_done
      send_frame(0, 14, 2, 1, 3, 0, 0, -1, 16'h0);
      send_frame(1, 1, 1, 0, 2, 1, 0, -1, 16'h1234);
      idle(3);
      chk("frame_len_back_to_back", 32'(frame_len), 32'd96);

      // Same frame as the first, with axiiv toggling every other cycle
      send_frame(0, 9, 0, 0, 1, 2, 1, -1, 16'h0);
      idle(3);

      // Reset in mid-body at counter = 200, then a clean frame
      send_frame(0, 9, 0, 0, 1, 2, 0, 197, 16'h0);
      idle(2);
      chk("counter_before_reset", counter, 32'd200);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(1, 11, 1, 1, 0, 3, 0, -1, 16'h5A5A);
      idle(3);

      // Randomised valid frames with random gaps
      for (int n = 0; n < 5; n++) begin
         crc_r = int'($urandom_range(0, 1));
         br_r  = int'($urandom_range(1, 14));
         sr_r  = int'($urandom_range(0, 2));
         send_frame(crc_r, br_r, sr_r, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1, 16'($urandom));
      end
      idle(5);

      chk("pending_bytes", 32'(exp_q.size()), 32'd0);
      chk("pending_headers", 32'(exp_h.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
